// File: rtl/ls_pkg.sv
// ls_pkg: definitions shared by the load/store arbiter files.
//   state_t          : arbiter sequencing states (IDLE, REQ, RSP)
//   GNT_AG/RD/AXIS   : bit positions of each requester in the one-hot grant
package ls_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2
    } state_t;

    localparam int GNT_AG   = 0;
    localparam int GNT_RD   = 1;
    localparam int GNT_AXIS = 2;

endpackage

// File: rtl/ls_arb_if.sv
// ls_arb_if: bundle of every requester, response and memory-port signal
// around the load/store arbiter.
//   hs_X4arb_val / i_X_*  : request valid and payload, X in {axis, rd, ag}
//   hs_arb4X_rdy, o_rdat  : one-cycle done strobe and response data
//   hs_arb4mem_val, o_mem_*, hs_mem4arb_rdy : command to the memory port
//   i_mem_rsp, i_mem_rdat : response strobe and data from memory
//   o_gnt, o_proto_err    : current owner and sticky protocol error
// Modports: slave = arbiter side, master = requesters plus memory side.
interface ls_arb_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          hs_axis4arb_val;
    logic [AW-1:0] i_axis_adr;
    logic [DW-1:0] i_axis_wdat;
    logic [3:0]    i_axis_wen;
    logic          i_axis_ren;

    logic          hs_rd4arb_val;
    logic [AW-1:0] i_rd_adr;
    logic [DW-1:0] i_rd_wdat;
    logic [3:0]    i_rd_wen;
    logic          i_rd_ren;

    logic          hs_ag4arb_val;
    logic [AW-1:0] i_ag_adr;
    logic [DW-1:0] i_ag_wdat;
    logic [3:0]    i_ag_wen;
    logic          i_ag_ren;

    logic          hs_arb4axis_rdy;
    logic          hs_arb4rd_rdy;
    logic          hs_arb4ag_rdy;
    logic [DW-1:0] o_rdat;

    logic          hs_arb4mem_val;
    logic          hs_mem4arb_rdy;
    logic [AW-1:0] o_mem_adr;
    logic [DW-1:0] o_mem_wdat;
    logic [3:0]    o_mem_wen;
    logic          o_mem_ren;
    logic          i_mem_rsp;
    logic [DW-1:0] i_mem_rdat;

    logic [2:0]    o_gnt;
    logic          o_proto_err;

    modport slave (
        input  hs_axis4arb_val, i_axis_adr, i_axis_wdat, i_axis_wen, i_axis_ren,
        input  hs_rd4arb_val, i_rd_adr, i_rd_wdat, i_rd_wen, i_rd_ren,
        input  hs_ag4arb_val, i_ag_adr, i_ag_wdat, i_ag_wen, i_ag_ren,
        output hs_arb4axis_rdy, hs_arb4rd_rdy, hs_arb4ag_rdy, o_rdat,
        output hs_arb4mem_val, o_mem_adr, o_mem_wdat, o_mem_wen, o_mem_ren,
        input  hs_mem4arb_rdy, i_mem_rsp, i_mem_rdat,
        output o_gnt, o_proto_err
    );

    modport master (
        output hs_axis4arb_val, i_axis_adr, i_axis_wdat, i_axis_wen, i_axis_ren,
        output hs_rd4arb_val, i_rd_adr, i_rd_wdat, i_rd_wen, i_rd_ren,
        output hs_ag4arb_val, i_ag_adr, i_ag_wdat, i_ag_wen, i_ag_ren,
        input  hs_arb4axis_rdy, hs_arb4rd_rdy, hs_arb4ag_rdy, o_rdat,
        input  hs_arb4mem_val, o_mem_adr, o_mem_wdat, o_mem_wen, o_mem_ren,
        output hs_mem4arb_rdy, i_mem_rsp, i_mem_rdat,
        input  o_gnt, o_proto_err
    );
endinterface

// File: rtl/ls_age_cnt.sv
// ls_age_cnt: saturating starvation counter for one low-priority requester.
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : requester's val
//   lose       : an IDLE arbitration was won by someone else
//   win        : this requester is being granted
//   aged       : counter has reached AGE_MAX; requester gets promoted
module ls_age_cnt #(
    parameter int AGE_MAX = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    input  logic lose,
    input  logic win,
    output logic aged
);
    localparam int CW = $clog2(AGE_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(AGE_MAX);

    logic [CW-1:0] cnt;

    // NOTE: clocked state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!req || win) begin
            cnt <= '0;
        end else if (lose && (cnt != CNT_MAX)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign aged = (cnt == CNT_MAX);

endmodule

// File: rtl/ls_arb.sv
// ls_arb: shares the single load/store memory port between AXIS, IFU (rd)
// and AGU (ag). One transaction outstanding; fixed priority with aging.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : ls_arb_if slave modport carrying all requester, response
//                and memory-port signals
module ls_arb
    import ls_pkg::*;
#(
    parameter int AGE_MAX = 8,
    parameter int AW      = 32,
    parameter int DW      = 32
) (
    input  logic      clk,
    input  logic      rst_n,
    ls_arb_if.slave   bus
);
    state_t        state, state_nxt;
    logic [2:0]    gnt;
    logic [2:0]    win;
    logic [2:0]    done;
    logic          rd_aged, ag_aged;
    logic          proto_err;

    logic [AW-1:0] mem_adr, sel_adr;
    logic [DW-1:0] mem_wdat, sel_wdat;
    logic [3:0]    mem_wen, sel_wen;
    logic          mem_ren, sel_ren;

    // The IFU is always a plain read, so its write payload is never used.
    logic unused_rd;
    assign unused_rd = ^{bus.i_rd_wdat, bus.i_rd_wen, bus.i_rd_ren};

    // Arbitration: aged rd, aged ag, axis, rd, ag. Only meaningful in IDLE.
    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path leaves it unassigned and infers a latch.
    always_comb begin
        win = '0;
        if (state == ST_IDLE) begin
            if (bus.hs_rd4arb_val && rd_aged)      win[GNT_RD]   = 1'b1;
            else if (bus.hs_ag4arb_val && ag_aged) win[GNT_AG]   = 1'b1;
            else if (bus.hs_axis4arb_val)          win[GNT_AXIS] = 1'b1;
            else if (bus.hs_rd4arb_val)            win[GNT_RD]   = 1'b1;
            else if (bus.hs_ag4arb_val)            win[GNT_AG]   = 1'b1;
        end
    end

    // Payload of the winner; rd is forced to a read with zero write data.
    always_comb begin
        sel_adr  = '0;
        sel_wdat = '0;
        sel_wen  = '0;
        sel_ren  = 1'b0;
        if (win[GNT_AXIS]) begin
            sel_adr  = bus.i_axis_adr;
            sel_wdat = bus.i_axis_wdat;
            sel_wen  = bus.i_axis_wen;
            sel_ren  = bus.i_axis_ren;
        end else if (win[GNT_RD]) begin
            sel_adr  = bus.i_rd_adr;
            sel_ren  = 1'b1;
        end else if (win[GNT_AG]) begin
            sel_adr  = bus.i_ag_adr;
            sel_wdat = bus.i_ag_wdat;
            sel_wen  = bus.i_ag_wen;
            sel_ren  = bus.i_ag_ren;
        end
    end

    // Starvation counters for the two promotable requesters.
    ls_age_cnt #(.AGE_MAX(AGE_MAX)) u_age_rd (
        .clk  (clk),
        .rst_n(rst_n),
        .req  (bus.hs_rd4arb_val),
        .lose ((|win) && !win[GNT_RD]),
        .win  (win[GNT_RD]),
        .aged (rd_aged)
    );

    ls_age_cnt #(.AGE_MAX(AGE_MAX)) u_age_ag (
        .clk  (clk),
        .rst_n(rst_n),
        .req  (bus.hs_ag4arb_val),
        .lose ((|win) && !win[GNT_AG]),
        .win  (win[GNT_AG]),
        .aged (ag_aged)
    );

    // FSM: state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // FSM: next state. Wait states in REQ and RSP are unbounded.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (|win)              state_nxt = ST_REQ;
            ST_REQ:  if (bus.hs_mem4arb_rdy) state_nxt = ST_RSP;
            ST_RSP:  if (bus.i_mem_rsp)      state_nxt = ST_IDLE;
            default:                         state_nxt = ST_IDLE;
        endcase
    end

    // FSM: outputs. Done strobe and read data pass straight through from
    // the memory response, gated to the current owner.
    always_comb begin
        bus.hs_arb4mem_val = (state == ST_REQ);
        done               = ((state == ST_RSP) && bus.i_mem_rsp) ? gnt : 3'b000;
        bus.o_rdat         = (|done) ? bus.i_mem_rdat : '0;
    end

    assign bus.hs_arb4axis_rdy = done[GNT_AXIS];
    assign bus.hs_arb4rd_rdy   = done[GNT_RD];
    assign bus.hs_arb4ag_rdy   = done[GNT_AG];

    // Grant, command payload (sampled only at IDLE->REQ) and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt       <= '0;
            mem_adr   <= '0;
            mem_wdat  <= '0;
            mem_wen   <= '0;
            mem_ren   <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            if (|win) begin
                gnt      <= win;
                mem_adr  <= sel_adr;
                mem_wdat <= sel_wdat;
                mem_wen  <= sel_wen;
                mem_ren  <= sel_ren;
            end else if ((state == ST_RSP) && bus.i_mem_rsp) begin
                gnt <= '0;
            end
            if (bus.i_mem_rsp && (state != ST_RSP)) proto_err <= 1'b1;
        end
    end

    assign bus.o_gnt       = gnt;
    assign bus.o_mem_adr   = mem_adr;
    assign bus.o_mem_wdat  = mem_wdat;
    assign bus.o_mem_wen   = mem_wen;
    assign bus.o_mem_ren   = mem_ren;
    assign bus.o_proto_err = proto_err;

endmodule
